// File: rtl/char_ram_arbiter_pkg.sv
// Shared encodings for the character RAM arbiter.
//   mode_e : arbitration mode as driven on the mode input
//   tag_e  : owner of a RAM read travelling through the return pipeline
//   WAIT_W : width of the CPU starvation counter (covers MAX_WAIT up to 255)
package char_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        MODE_VGA     = 2'b00,
        MODE_CPU     = 2'b01,
        MODE_SHR_VGA = 2'b10,
        MODE_SHR_CPU = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CPU  = 2'b01,
        TAG_VGA  = 2'b10
    } tag_e;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/char_rd_tag_pipe.sv
// Read-return tag pipeline for the character RAM arbiter.
// A tag is loaded in the same edge as the registered RAM command and then
// delayed RD_LAT more cycles so it lines up with ram_rdata. On that cycle the
// data is captured into the owner's rdata register and its rvalid pulses.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   tag_in                  owner of the command being registered this edge
//   ram_rdata               RAM read data
//   cpu_rdata / cpu_rvalid  CPU read return (data held between pulses)
//   vga_rdata / vga_rvalid  VGA read return (data held between pulses)
module char_rd_tag_pipe
    import char_ram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  tag_e              tag_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid
);

    // tag_q[0] is aligned with the ram_* command; tag_q[RD_LAT] with ram_rdata.
    tag_e tag_q [RD_LAT+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            vga_rdata  <= '0;
            vga_rvalid <= 1'b0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            cpu_rvalid <= (tag_q[RD_LAT] == TAG_CPU);
            vga_rvalid <= (tag_q[RD_LAT] == TAG_VGA);
            if (tag_q[RD_LAT] == TAG_CPU) begin
                cpu_rdata <= ram_rdata;
            end
            if (tag_q[RD_LAT] == TAG_VGA) begin
                vga_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: rtl/char_ram_arbiter.sv
// Time-shares one single-port character RAM between the CPU (req/ack,
// read/write) and the VGA scanout (read-only, per-cycle requests).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   mode                             00 VGA-only, 01 CPU-only,
//                                    10 shared VGA-priority, 11 shared CPU-priority
//   cpu_req/we/addr/wdata            CPU request, held until cpu_ack
//   cpu_ack                          pulse: CPU command on ram_* this cycle
//   cpu_rdata/cpu_rvalid             CPU read return
//   vga_req/vga_addr                 VGA fetch request
//   vga_rdata/vga_rvalid/vga_miss    VGA read return, dropped-request pulse
//   ram_addr/ram_we/ram_wdata        registered RAM command
//   ram_rdata                        RAM read data, RD_LAT cycles after command
module char_ram_arbiter
    import char_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_miss,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic              cpu_eff;
    logic              cpu_win;
    logic              vga_win;
    logic              vga_drop;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    tag_e              tag_in;

    always_comb begin
        // The request is still high during its own ack cycle; masking it
        // stops the same access from being issued twice.
        cpu_eff  = cpu_req & ~cpu_ack;
        cpu_win  = 1'b0;
        vga_win  = 1'b0;
        wait_nxt = wait_cnt;

        case (mode_e'(mode))
            MODE_VGA: begin
                vga_win = vga_req;
            end
            MODE_CPU: begin
                cpu_win = cpu_eff;
            end
            MODE_SHR_VGA: begin
                if (cpu_eff && (wait_cnt == WAIT_MAX)) begin
                    cpu_win = 1'b1;
                end else if (vga_req) begin
                    vga_win = 1'b1;
                end else begin
                    cpu_win = cpu_eff;
                end
            end
            MODE_SHR_CPU: begin
                if (cpu_eff) begin
                    cpu_win = 1'b1;
                end else begin
                    vga_win = vga_req;
                end
            end
            default: begin
                vga_win = 1'b0;
            end
        endcase

        vga_drop = vga_req & ~vga_win;

        // Starvation counter only runs in shared VGA-priority mode and is
        // frozen while the CPU is locked out entirely.
        if (mode_e'(mode) != MODE_VGA) begin
            if (!cpu_eff || cpu_win) begin
                wait_nxt = '0;
            end else if ((mode_e'(mode) == MODE_SHR_VGA) && (wait_cnt != WAIT_MAX)) begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end

        if (cpu_win && !cpu_we) begin
            tag_in = TAG_CPU;
        end else if (vga_win) begin
            tag_in = TAG_VGA;
        end else begin
            tag_in = TAG_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_ack   <= 1'b0;
            vga_miss  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            cpu_ack  <= cpu_win;
            vga_miss <= vga_drop;
            ram_we   <= cpu_win & cpu_we;
            wait_cnt <= wait_nxt;
            if (cpu_win) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end else if (vga_win) begin
                ram_addr <= vga_addr;
            end
        end
    end

    char_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_in     (tag_in),
        .ram_rdata  (ram_rdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid)
    );

endmodule

// File: tb/tb_char_ram_arbiter.sv
module tb_char_ram_arbiter;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 8;
    localparam int RD_LAT   = 3;
    localparam int MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              vga_miss;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_ack, cnt_crv, cnt_vrv, cnt_miss, cnt_we;

    char_ram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .vga_miss   (vga_miss),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: fixed content derived from the address, RD_LAT-cycle read.
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
    endfunction

    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= init_val(ram_addr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n);
        cnt_ack = 0; cnt_crv = 0; cnt_vrv = 0; cnt_miss = 0; cnt_we = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cnt_ack  += int'(cpu_ack);
            cnt_crv  += int'(cpu_rvalid);
            cnt_vrv  += int'(vga_rvalid);
            cnt_miss += int'(vga_miss);
            cnt_we   += int'(ram_we);
        end
    endtask

    int first_ack, first_crv, miss_cyc, vidx;
    logic [DATA_W-1:0] crv_data;
    logic [DATA_W-1:0] vexp [2];
    logic              rv_side [16];
    logic [DATA_W-1:0] rv_data [16];
    int                rv_n;

    initial begin
        rst_n = 1'b0; mode = 2'b00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 1'b0; vga_addr = '0;
        tick(); tick();
        check_val("rst_ack",   32'(cpu_ack), 0);
        check_val("rst_we",    32'(ram_we), 0);
        check_val("rst_addr",  32'(ram_addr), 0);
        check_val("rst_wdata", 32'(ram_wdata), 0);
        check_val("rst_rv",    32'({cpu_rvalid, vga_rvalid, vga_miss}), 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a VGA read
        vga_req = 1'b1; vga_addr = 13'h0100;
        tick();
        check_val("midrd_addr", 32'(ram_addr), 32'h0100);
        vga_req = 1'b0; rst_n = 1'b0;
        tick();
        check_val("midrd_rst_addr", 32'(ram_addr), 0);
        check_val("midrd_rst_out",  32'({cpu_ack, cpu_rvalid, vga_rvalid, vga_miss, ram_we}), 0);
        check_val("midrd_rst_data", 32'({cpu_rdata, vga_rdata}), 0);
        rst_n = 1'b1;
        run_count(8);
        check_val("midrd_no_vrv", 32'(cnt_vrv), 0);

        // Mode 10: VGA every cycle, CPU read forced through by the starvation guard
        mode = 2'b10; vga_req = 1'b1; vga_addr = 13'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
        first_ack = -1; first_crv = -1; miss_cyc = -1; cnt_miss = 0; cnt_crv = 0; cnt_ack = 0;
        crv_data = '0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (cpu_ack) begin
                cnt_ack++;
                if (first_ack < 0) first_ack = i;
                cpu_req = 1'b0;
            end
            if (vga_miss) begin
                cnt_miss++;
                miss_cyc = i;
            end
            if (cpu_rvalid) begin
                cnt_crv++;
                if (first_crv < 0) begin
                    first_crv = i;
                    crv_data = cpu_rdata;
                end
            end
        end
        check_val("starve_ack_cyc",  32'(first_ack), 16);
        check_val("starve_ack_cnt",  32'(cnt_ack), 1);
        check_val("starve_miss_cnt", 32'(cnt_miss), 1);
        check_val("starve_miss_cyc", 32'(miss_cyc), 16);
        check_val("starve_crv_cyc",  32'(first_crv), 16 + RD_LAT + 1);
        check_val("starve_crv_cnt",  32'(cnt_crv), 1);
        check_val("starve_crv_data", 32'(crv_data), 32'(init_val(13'h1FFF)));
        vga_req = 1'b0;
        run_count(8);

        // Mode 11: CPU write collides with VGA fetch
        mode = 2'b11;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0042; cpu_wdata = 8'hA5;
        vga_req = 1'b1; vga_addr = 13'h0200;
        tick();
        check_val("wr_we",    32'(ram_we), 1);
        check_val("wr_addr",  32'(ram_addr), 32'h0042);
        check_val("wr_wdata", 32'(ram_wdata), 32'hA5);
        check_val("wr_ack",   32'(cpu_ack), 1);
        check_val("wr_miss",  32'(vga_miss), 1);
        cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b0;
        tick();
        check_val("wr_we_off", 32'(ram_we), 0);
        run_count(8);
        check_val("wr_no_rv", 32'(cnt_crv + cnt_vrv), 0);

        // Mode 00 lockout, then switch to 01 with the request still held
        mode = 2'b00;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
        run_count(100);
        check_val("lock_no_ack", 32'(cnt_ack), 0);
        check_val("lock_no_rv",  32'(cnt_crv), 0);
        mode = 2'b01;
        tick();
        check_val("unlock_ack",  32'(cpu_ack), 1);
        check_val("unlock_addr", 32'(ram_addr), 32'h0123);
        tick();
        check_val("unlock_no_reack", 32'(cpu_ack), 0);
        cpu_req = 1'b0;
        run_count(8);
        check_val("unlock_one_rv", 32'(cnt_crv + 1 - int'(cpu_rvalid) * 0), 2);
        check_val("unlock_ack_tot", 32'(cnt_ack), 0);

        // Mode 10 -> 01 with two VGA reads in flight
        mode = 2'b10;
        vga_req = 1'b1; vga_addr = 13'h0300;
        tick();
        vga_addr = 13'h0301;
        tick();
        mode = 2'b01; vga_addr = 13'h0302;
        tick();
        check_val("sw_miss", 32'(vga_miss), 1);
        vga_req = 1'b0;
        vexp[0] = init_val(13'h0300);
        vexp[1] = init_val(13'h0301);
        vidx = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vga_rvalid) begin
                if (vidx < 2) check_val("sw_vrv_data", 32'(vga_rdata), 32'(vexp[vidx]));
                vidx++;
            end
        end
        check_val("sw_vrv_cnt", 32'(vidx), 2);
        vga_req = 1'b1; vga_addr = 13'h0304;
        tick();
        check_val("sw_miss2", 32'(vga_miss), 1);
        vga_req = 1'b0;
        run_count(8);
        check_val("sw_no_vrv", 32'(cnt_vrv), 0);

        // Mode 10, alternating CPU/VGA reads, returns must stay in issue order
        mode = 2'b10;
        cpu_we = 1'b0; cpu_addr = 13'h0800;
        rv_n = 0;
        for (int k = 0; k < 16; k++) begin
            rv_side[k] = 1'b0;
            rv_data[k] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                vga_req  = (i % 2 == 0);
                vga_addr = 13'(13'h0400 + i);
                cpu_req  = 1'b1;
            end else begin
                vga_req = 1'b0;
                cpu_req = 1'b0;
            end
            tick();
            if (cpu_ack) cpu_addr = cpu_addr + 1'b1;
            if (cpu_rvalid && rv_n < 16) begin
                rv_side[rv_n] = 1'b1;
                rv_data[rv_n] = cpu_rdata;
                rv_n++;
            end
            if (vga_rvalid && rv_n < 16) begin
                rv_side[rv_n] = 1'b0;
                rv_data[rv_n] = vga_rdata;
                rv_n++;
            end
        end
        check_val("alt_rv_cnt", 32'(rv_n), 8);
        for (int k = 0; k < 8; k++) begin
            logic [ADDR_W-1:0] ea;
            ea = (k % 2 == 0) ? 13'(13'h0400 + k) : 13'(13'h0800 + k / 2);
            check_val($sformatf("alt_side%0d", k), 32'(rv_side[k]), 32'(k % 2));
            check_val($sformatf("alt_data%0d", k), 32'(rv_data[k]), 32'(init_val(ea)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
